att_peso_seq: RTL and testbench
===============================

ATT_PESO_SEQ -- requirements
Module: att_peso_seq

Interface
REQ-001 SHALL have parameter N_IN, default 4, number of input channels/weights (1..64).
REQ-002 SHALL have parameter WIDTH, default 16, bit width of every operand and weight.
REQ-003 SHALL have parameter FRAC, default 10, fractional bits of the two's-complement fixed-point format.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 en  in  1  FSM advance enable; low = stall.
REQ-007 start  in  1  request one weight-update pass.
REQ-008 d  in  WIDTH  desired output.
REQ-009 y  in  WIDTH  actual neuron output.
REQ-010 u  in  WIDTH  learning rate.
REQ-011 in_vec  in  N_IN*WIDTH  input samples; channel i at bits [i*WIDTH +: WIDTH].
REQ-012 wload  in  1  weight preload strobe.
REQ-013 wsel  in  clog2(N_IN) (min 1)  preload channel index.
REQ-014 wdata  in  WIDTH  preload value.
REQ-015 w_vec  out  N_IN*WIDTH  registered weight bank, same packing as in_vec.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 done  out  1  one-cycle completion pulse.
REQ-018 zero_err  out  1  valid with done; pass had e == 0.
REQ-019 sat  out  1  valid with done; any saturation occurred during the pass.

Function
REQ-020 States SHALL be IDLE, ERR, UPD, DONE; IDLE->ERR on start&en, ERR->DONE if e==0 else ERR->UPD, UPD->DONE after channel N_IN-1, DONE->IDLE unconditionally.
REQ-021 On the edge accepting start, d, y, u, in_vec SHALL be captured; later input changes SHALL not affect the pass.
REQ-022 ERR SHALL compute e = sat(d - y) and k = sat((u*e) >>> FRAC), stored for the pass.
REQ-023 UPD SHALL process one channel per cycle, index 0 upward: w[i] <= sat(w[i] + sat((k*in[i]) >>> FRAC)).
REQ-024 Products SHALL be full 2*WIDTH signed, arithmetic shift right FRAC (round toward -inf), then saturated.
REQ-025 sat() SHALL clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; any clamp sets the pass sat flag.
REQ-026 done SHALL rise N_IN+2 cycles after the accepting edge (2 cycles when e==0), absent stalls.
REQ-027 While en=0 the FSM, index and weights SHALL hold; done stays high during a stall in DONE.
REQ-028 start while busy SHALL be ignored; start in IDLE with en=0 SHALL be ignored.
REQ-029 wload in IDLE SHALL write wdata to w[wsel] next edge; wload while busy or wsel>=N_IN SHALL be ignored.
REQ-030 wload and start in the same IDLE cycle: wload SHALL be applied first, then the pass SHALL use the loaded weight.
REQ-031 zero_err and sat SHALL hold their value from DONE until the next accepted start.

Reset
REQ-032 rst SHALL force IDLE, all weights 0, index 0, busy=0, done=0, zero_err=0, sat=0, immediately, including mid-pass.

Structure
REQ-033 WIDTH/FRAC defaults and state encodings SHALL live in the shared training header used by the training modules.
REQ-034 Multiply-shift-saturate SHALL be a sub-module fx_mul_sat, instantiated for both k and per-channel delta.

Verification
REQ-035 Reset: assert rst mid-UPD -> w_vec=0, busy=0, done=0 same cycle.
REQ-036 Basic: N_IN=4, w=0, u=0x0200, d=0x0400, y=0, in all 0x0400 -> done 6 cycles after start, each w=0x0200, sat=0.
REQ-037 Zero error: d=y=0x0400 -> done 2 cycles after start, zero_err=1, weights unchanged.
REQ-038 Saturation: preload w[0]=0x7E00, u=0x0400, d=0x0400, y=0, in[0]=0x0400 -> w[0]=0x7FFF, sat=1; d=0x8000, y=0x7FFF -> e clamps to 0x8000.
REQ-039 Stall: en low 3 cycles during UPD -> done 9 cycles after start, weights match basic case.
REQ-040 Ignored requests: start and wload while busy -> no restart, weights follow only the running pass.

Source files
------------

// File: rtl/att_peso_seq_pkg.sv
// Shared training header: fixed-point defaults and the weight-update FSM encoding.
package att_peso_seq_pkg;
   localparam int DEF_WIDTH = 16;
   localparam int DEF_FRAC  = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ERR  = 2'd1,
      UPD  = 2'd2,
      DONE = 2'd3
   } state_t;
endpackage

// File: rtl/att_peso_seq_fx_mul_sat.sv
// Signed fixed-point multiply: full-width product, floor shift by FRAC, clamp to WIDTH.
module fx_mul_sat #(
   parameter int WIDTH = 16,
   parameter int FRAC  = 10
) (
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   output logic signed [WIDTH-1:0] p,
   output logic                    ovf
);
   localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};

   logic signed [2*WIDTH-1:0] prod, shf;
   logic [WIDTH:0] hi;

   assign prod = a * b;
   assign shf  = prod >>> FRAC;
   // Result fits only if the top WIDTH+1 bits are pure sign extension.
   assign hi   = shf[2*WIDTH-1:WIDTH-1];
   assign ovf  = !((&hi) || (~|hi));
   assign p    = ovf ? (shf[2*WIDTH-1] ? ~MAXV : MAXV) : shf[WIDTH-1:0];
endmodule

// File: rtl/att_peso_seq.sv
// Sequential delta-rule weight update: one error/gain step, then one channel per cycle.
module att_peso_seq
   import att_peso_seq_pkg::*;
#(
   parameter int N_IN  = 4,
   parameter int WIDTH = DEF_WIDTH,
   parameter int FRAC  = DEF_FRAC,
   localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    start,
   input  logic [WIDTH-1:0]        d,
   input  logic [WIDTH-1:0]        y,
   input  logic [WIDTH-1:0]        u,
   input  logic [N_IN*WIDTH-1:0]   in_vec,
   input  logic                    wload,
   input  logic [IDX_W-1:0]        wsel,
   input  logic [WIDTH-1:0]        wdata,
   output logic [N_IN*WIDTH-1:0]   w_vec,
   output logic                    busy,
   output logic                    done,
   output logic                    zero_err,
   output logic                    sat
);
   localparam logic [WIDTH-1:0] MAXV   = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [IDX_W:0]   N_IN_L = N_IN[IDX_W:0];
   localparam logic [IDX_W-1:0] LAST   = N_IN_L[IDX_W-1:0] - 1'b1;

   state_t                        state;
   logic [IDX_W-1:0]              idx;
   logic [N_IN-1:0][WIDTH-1:0]    w_bank, in_r;
   logic [WIDTH-1:0]              d_r, y_r, u_r, k_r;
   logic                          sat_acc;

   logic [WIDTH:0]   diff_x, sum_x;
   logic [WIDTH-1:0] e_sat, k_p, dlt_p, sum_sat;
   logic             e_ovf, k_ovf, dlt_ovf, sum_ovf, sat_upd;

   // Error, widened by one bit so d-y never wraps before clamping.
   assign diff_x  = {d_r[WIDTH-1], d_r} - {y_r[WIDTH-1], y_r};
   assign e_ovf   = diff_x[WIDTH] ^ diff_x[WIDTH-1];
   assign e_sat   = e_ovf ? (diff_x[WIDTH] ? ~MAXV : MAXV) : diff_x[WIDTH-1:0];

   fx_mul_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_k_mul (
      .a(u_r), .b(e_sat), .p(k_p), .ovf(k_ovf)
   );

   fx_mul_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_dlt_mul (
      .a(k_r), .b(in_r[idx]), .p(dlt_p), .ovf(dlt_ovf)
   );

   assign sum_x   = {w_bank[idx][WIDTH-1], w_bank[idx]} + {dlt_p[WIDTH-1], dlt_p};
   assign sum_ovf = sum_x[WIDTH] ^ sum_x[WIDTH-1];
   assign sum_sat = sum_ovf ? (sum_x[WIDTH] ? ~MAXV : MAXV) : sum_x[WIDTH-1:0];
   assign sat_upd = sat_acc | dlt_ovf | sum_ovf;

   assign w_vec = w_bank;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         idx      <= '0;
         w_bank   <= '0;
         in_r     <= '0;
         d_r      <= '0;
         y_r      <= '0;
         u_r      <= '0;
         k_r      <= '0;
         sat_acc  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         zero_err <= 1'b0;
         sat      <= 1'b0;
      end else if (en) begin
         case (state)
            IDLE: begin
               // A same-cycle preload lands before UPD reads the bank.
               if (wload && ({1'b0, wsel} < N_IN_L))
                  w_bank[wsel] <= wdata;
               if (start) begin
                  d_r      <= d;
                  y_r      <= y;
                  u_r      <= u;
                  in_r     <= in_vec;
                  idx      <= '0;
                  sat_acc  <= 1'b0;
                  zero_err <= 1'b0;
                  sat      <= 1'b0;
                  busy     <= 1'b1;
                  state    <= ERR;
               end
            end
            ERR: begin
               k_r     <= k_p;
               sat_acc <= e_ovf | k_ovf;
               if (e_sat == '0) begin
                  zero_err <= 1'b1;
                  sat      <= e_ovf | k_ovf;
                  done     <= 1'b1;
                  state    <= DONE;
               end else begin
                  state <= UPD;
               end
            end
            UPD: begin
               w_bank[idx] <= sum_sat;
               sat_acc     <= sat_upd;
               if (idx == LAST) begin
                  idx   <= '0;
                  sat   <= sat_upd;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_att_peso_seq.sv
// Bench for att_peso_seq: directed vector table, hand sequences, randomized passes vs model.
module tb_att_peso_seq;
   localparam int N_IN = 4;
   localparam int W    = 16;
   localparam int FRAC = 10;
   localparam longint MAXV = 32767;
   localparam longint MINV = -32768;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   en = 1'b1, start = 1'b0, wload = 1'b0;
   logic [W-1:0]           d = '0, y = '0, u = '0, wdata = '0;
   logic [N_IN-1:0][W-1:0] in_vec = '0;
   logic [1:0]             wsel = '0;
   logic [N_IN*W-1:0]      w_vec;
   logic                   busy, done, zero_err, sat;

   int checks = 0, failures = 0;
   longint mw [N_IN];

   att_peso_seq #(.N_IN(N_IN), .WIDTH(W), .FRAC(FRAC)) dut (
      .clk(clk), .rst(rst), .en(en), .start(start), .d(d), .y(y), .u(u),
      .in_vec(in_vec), .wload(wload), .wsel(wsel), .wdata(wdata),
      .w_vec(w_vec), .busy(busy), .done(done), .zero_err(zero_err), .sat(sat)
   );

   always #5 clk = ~clk;

   typedef struct {
      string                  name;
      logic [N_IN-1:0][W-1:0] w_init;
      logic [W-1:0]           d, y, u;
      logic [N_IN-1:0][W-1:0] inv;
      int                     stall_at, stall_len;
      bit                     noise, ld0;
      logic [W-1:0]           ld0_val;
      logic [N_IN-1:0][W-1:0] w_exp;
      int                     lat;
      bit                     sat_exp, zero_exp;
   } vec_t;

   vec_t tbl [7];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic longint sx(input logic [W-1:0] v);
      return longint'($signed(v));
   endfunction

   function automatic longint clampf(input longint x, inout bit f);
      if (x > MAXV) begin f = 1'b1; return MAXV; end
      if (x < MINV) begin f = 1'b1; return MINV; end
      return x;
   endfunction

   // Reference: whole pass computed with plain integer arithmetic on mw[].
   task automatic model_pass(input logic [W-1:0] md, my, mu, input logic [N_IN-1:0][W-1:0] inv,
                             output int lat, output bit s, output bit z);
      bit f = 1'b0;
      longint e, k;
      e = clampf(sx(md) - sx(my), f);
      z = (e == 0);
      k = clampf((sx(mu) * e) >>> FRAC, f);
      if (!z)
         for (int i = 0; i < N_IN; i++)
            mw[i] = clampf(mw[i] + clampf((k * sx(inv[i])) >>> FRAC, f), f);
      lat = z ? 2 : N_IN + 2;
      s = f;
   endtask

   task automatic preload(input logic [N_IN-1:0][W-1:0] wv);
      for (int i = 0; i < N_IN; i++) begin
         wload = 1'b1; wsel = 2'(i); wdata = wv[i];
         @(posedge clk); #1;
         mw[i] = sx(wv[i]);
      end
      wload = 1'b0;
   endtask

   // Drives one pass; returns edges from accept to done observed (accept edge counts as 1).
   task automatic run_vec(input logic [W-1:0] vd, vy, vu, input logic [N_IN-1:0][W-1:0] inv,
                          input int st_at, st_len, input bit noise, ld0,
                          input logic [W-1:0] ld0_val, output int lat);
      int cnt = 0;
      d = vd; y = vy; u = vu; in_vec = inv; start = 1'b1; en = 1'b1;
      if (ld0) begin wload = 1'b1; wsel = 2'd0; wdata = ld0_val; end
      while (cnt < 100) begin
         @(posedge clk); #1;
         cnt++;
         start = 1'b0; wload = 1'b0;
         if (done) break;
         if (noise) begin
            start = 1'b1; wload = 1'b1; wsel = 2'($urandom_range(0, 3));
            wdata = 16'($urandom); d = 16'($urandom); y = 16'($urandom);
            u = 16'($urandom); in_vec = {N_IN{16'($urandom)}};
         end
         en = !(st_len > 0 && cnt >= st_at && cnt < st_at + st_len);
      end
      if (cnt >= 100) chk("done_timeout", 0, 1);
      start = 1'b0; wload = 1'b0; en = 1'b1;
      lat = cnt;
   endtask

   task automatic check_w(input string tag);
      for (int i = 0; i < N_IN; i++)
         chk($sformatf("%s_w%0d", tag, i), sx(w_vec[i*W +: W]), mw[i]);
   endtask

   initial begin
      int  lat, elat;
      bit  es, ez, hs, hz;
      logic [W-1:0] rd, ry, ru;
      logic [N_IN-1:0][W-1:0] rin;

      tbl[0] = '{"basic", '0, 16'h0400, 16'h0000, 16'h0200, {N_IN{16'h0400}}, 0, 0, 1'b0, 1'b0, 16'h0,
                 {N_IN{16'h0200}}, 6, 1'b0, 1'b0};
      tbl[1] = '{"zero_err", {16'h0400, 16'h0300, 16'h0200, 16'h0100}, 16'h0400, 16'h0400, 16'h0200,
                 {N_IN{16'h0400}}, 0, 0, 1'b0, 1'b0, 16'h0,
                 {16'h0400, 16'h0300, 16'h0200, 16'h0100}, 2, 1'b0, 1'b1};
      tbl[2] = '{"sat_w0", '0, 16'h0400, 16'h0000, 16'h0400, {16'h0, 16'h0, 16'h0, 16'h0400},
                 0, 0, 1'b0, 1'b1, 16'h7E00, {16'h0, 16'h0, 16'h0, 16'h7FFF}, 6, 1'b1, 1'b0};
      tbl[3] = '{"e_clamp", '0, 16'h8000, 16'h7FFF, 16'h0400, {N_IN{16'h0400}}, 0, 0, 1'b0, 1'b0, 16'h0,
                 {N_IN{16'h8000}}, 6, 1'b1, 1'b0};
      tbl[4] = '{"stall", '0, 16'h0400, 16'h0000, 16'h0200, {N_IN{16'h0400}}, 3, 3, 1'b0, 1'b0, 16'h0,
                 {N_IN{16'h0200}}, 9, 1'b0, 1'b0};
      tbl[5] = '{"ignored", '0, 16'h0400, 16'h0000, 16'h0200, {N_IN{16'h0400}}, 0, 0, 1'b1, 1'b0, 16'h0,
                 {N_IN{16'h0200}}, 6, 1'b0, 1'b0};
      tbl[6] = '{"floor", '0, 16'h0000, 16'h0001, 16'h0400, {16'h7FFF, 16'h0400, 16'h0003, 16'h0001},
                 0, 0, 1'b0, 1'b0, 16'h0, {16'hFFE0, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 6, 1'b0, 1'b0};

      for (int i = 0; i < N_IN; i++) mw[i] = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_w", longint'(w_vec), 0);
      chk("rst_busy", longint'(busy), 0);
      chk("rst_done", longint'(done), 0);
      chk("rst_zero", longint'(zero_err), 0);
      chk("rst_sat", longint'(sat), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int t = 0; t < 7; t++) begin
         preload(tbl[t].w_init);
         run_vec(tbl[t].d, tbl[t].y, tbl[t].u, tbl[t].inv, tbl[t].stall_at, tbl[t].stall_len,
                 tbl[t].noise, tbl[t].ld0, tbl[t].ld0_val, lat);
         chk({tbl[t].name, "_lat"}, lat, tbl[t].lat);
         chk({tbl[t].name, "_sat"}, longint'(sat), longint'(tbl[t].sat_exp));
         chk({tbl[t].name, "_zero"}, longint'(zero_err), longint'(tbl[t].zero_exp));
         chk({tbl[t].name, "_w"}, longint'(w_vec), longint'(tbl[t].w_exp));
         @(posedge clk); #1;
         chk({tbl[t].name, "_idle_busy"}, longint'(busy), 0);
         chk({tbl[t].name, "_hold_sat"}, longint'(sat), longint'(tbl[t].sat_exp));
         for (int i = 0; i < N_IN; i++) mw[i] = sx(tbl[t].w_exp[i]);
      end

      // done must stay up while stalled in DONE
      preload('0);
      run_vec(16'h0400, 16'h0000, 16'h0200, {N_IN{16'h0400}}, 0, 0, 1'b0, 1'b0, 16'h0, lat);
      en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("done_stall_done", longint'(done), 1);
      chk("done_stall_busy", longint'(busy), 1);
      en = 1'b1;
      @(posedge clk); #1;
      chk("done_stall_release", longint'(done), 0);

      // start with en low is dropped
      en = 1'b0; start = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      start = 1'b0; en = 1'b1;
      @(posedge clk); #1;
      chk("start_en0_busy", longint'(busy), 0);
      for (int i = 0; i < N_IN; i++) mw[i] = 512;

      // randomized passes against the model, weights carried across passes
      for (int r = 0; r < 25; r++) begin
         rd  = 16'($urandom);
         ry  = ($urandom_range(0, 4) == 0) ? rd : 16'($urandom_range(0, 16'h0800));
         ru  = 16'($urandom_range(0, 16'h0600));
         for (int i = 0; i < N_IN; i++) rin[i] = 16'($urandom);
         model_pass(rd, ry, ru, rin, elat, es, ez);
         hs = ($urandom_range(0, 1) == 1);
         run_vec(rd, ry, ru, rin, hs ? $urandom_range(1, elat - 1) : 0, hs ? $urandom_range(1, 3) : 0,
                 1'($urandom_range(0, 1)), 1'b0, 16'h0, lat);
         if (hs) chk($sformatf("rnd%0d_lat_min", r), longint'(lat > elat), 1);
         else    chk($sformatf("rnd%0d_lat", r), lat, elat);
         chk($sformatf("rnd%0d_sat", r), longint'(sat), longint'(es));
         hz = zero_err;
         chk($sformatf("rnd%0d_zero", r), longint'(hz), longint'(ez));
         check_w($sformatf("rnd%0d", r));
         @(posedge clk); #1;
      end

      // asynchronous reset in the middle of UPD
      preload({N_IN{16'h0100}});
      d = 16'h0400; y = '0; u = 16'h0200; in_vec = {N_IN{16'h0400}}; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_mid_w", longint'(w_vec), 0);
      chk("rst_mid_busy", longint'(busy), 0);
      chk("rst_mid_done", longint'(done), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
